// File: rtl/rvh_l1d_wb_arb_pkg.sv
// rtl/rvh_l1d_wb_arb_pkg.sv - shared private-cache <-> SCU coherence payload types
package rvh_l1d_wb_arb_pkg;

    localparam int CACHE_MASTERID_W = 3;
    localparam int CACHE_COREID_W   = 4;

    // bid carries one spare msb above the bank index; a set msb never routes.
    typedef struct packed {
        logic [CACHE_COREID_W-1:0]   cid;
        logic [CACHE_MASTERID_W:0]   bid;
    } cache_scu_cc_id_t;

    typedef struct packed {
        cache_scu_cc_id_t id;
        logic [2:0]       op;
        logic [39:0]      addr;
    } cache_scu_cc_req_t;

    typedef struct packed {
        cache_scu_cc_id_t id;
        logic [63:0]      data;
        logic             last;
    } cache_scu_cc_data_t;

    typedef struct packed {
        cache_scu_cc_id_t id;
        logic [2:0]       op;
        logic [1:0]       state;
        logic [63:0]      data;
    } cache_scu_cc_resp_t;

endpackage

// File: rtl/rvh_l1d_wb_arb.sv
// rtl/rvh_l1d_wb_arb.sv - L1D bank evict/data merger with RR arbitration and response routing (option: RVH_L1D_WB_ARB_RESP_PIPE_EN)
module rvh_l1d_wb_arb
    import rvh_l1d_wb_arb_pkg::*;
#(
    parameter int N_BANK  = 2,
    parameter int CORE_ID = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic               [N_BANK-1:0]      bank_evict_vld_i,
    input  cache_scu_cc_req_t  [N_BANK-1:0]      bank_evict_i,
    output logic               [N_BANK-1:0]      bank_evict_rdy_o,
    input  logic               [N_BANK-1:0]      bank_data_vld_i,
    input  cache_scu_cc_data_t [N_BANK-1:0]      bank_data_i,
    output logic               [N_BANK-1:0]      bank_data_rdy_o,
    output logic               [N_BANK-1:0]      bank_resp_vld_o,
    output cache_scu_cc_resp_t [N_BANK-1:0]      bank_resp_o,
    input  logic               [N_BANK-1:0]      bank_resp_rdy_i,
    output logic                                 pc_scu_evict_vld_o,
    output cache_scu_cc_req_t                    pc_scu_evict_o,
    input  logic                                 pc_scu_evict_rdy_i,
    output logic                                 pc_scu_data_vld_o,
    output cache_scu_cc_data_t                   pc_scu_data_o,
    input  logic                                 pc_scu_data_rdy_i,
    input  logic                                 scu_pc_resp_vld_i,
    input  cache_scu_cc_resp_t                   scu_pc_resp_i,
    output logic                                 scu_pc_resp_rdy_o,
    output logic                                 resp_misroute_o
);

    localparam int PTR_W = (N_BANK > 1) ? $clog2(N_BANK) : 1;

    // First valid bank at or after ptr, wrapping; caller guarantees some vld bit is set.
    function automatic logic [PTR_W-1:0] rr_winner(input logic [N_BANK-1:0] vld,
                                                   input logic [PTR_W-1:0]  ptr);
        int best;
        int off;
        rr_winner = '0;
        best      = N_BANK;
        for (int j = 0; j < N_BANK; j++) begin
            off = (j - int'(ptr) + N_BANK) % N_BANK;
            if (vld[j] && off < best) begin
                best      = off;
                rr_winner = PTR_W'(j);
            end
        end
    endfunction

    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] win);
        rr_next = PTR_W'((int'(win) + 1) % N_BANK);
    endfunction

    logic               ev_vld_q, ev_vld_d, dt_vld_q, dt_vld_d;
    logic [PTR_W-1:0]   ev_ptr_q, ev_ptr_d, dt_ptr_q, dt_ptr_d;
    cache_scu_cc_req_t  ev_pay_q, ev_pay_d;
    cache_scu_cc_data_t dt_pay_q, dt_pay_d;
    logic               misroute_q, misroute_d;
    logic [PTR_W-1:0]   ev_win, dt_win;
    logic               ev_load, dt_load;

    // Evict and data channels: arbitrate, hand the winner its ready, load the output register.
    always_comb begin
        ev_win           = rr_winner(bank_evict_vld_i, ev_ptr_q);
        dt_win           = rr_winner(bank_data_vld_i, dt_ptr_q);
        ev_load          = (~ev_vld_q | pc_scu_evict_rdy_i) & (|bank_evict_vld_i);
        dt_load          = (~dt_vld_q | pc_scu_data_rdy_i) & (|bank_data_vld_i);
        bank_evict_rdy_o = '0;
        bank_data_rdy_o  = '0;
        ev_pay_d         = ev_pay_q;
        dt_pay_d         = dt_pay_q;
        ev_ptr_d         = ev_load ? rr_next(ev_win) : ev_ptr_q;
        dt_ptr_d         = dt_load ? rr_next(dt_win) : dt_ptr_q;
        ev_vld_d         = ev_load | (ev_vld_q & ~pc_scu_evict_rdy_i);
        dt_vld_d         = dt_load | (dt_vld_q & ~pc_scu_data_rdy_i);
        for (int j = 0; j < N_BANK; j++) begin
            if (ev_load && ev_win == PTR_W'(j)) begin
                bank_evict_rdy_o[j] = 1'b1;
                ev_pay_d            = bank_evict_i[j];
            end
            if (dt_load && dt_win == PTR_W'(j)) begin
                bank_data_rdy_o[j] = 1'b1;
                dt_pay_d           = bank_data_i[j];
            end
        end
    end

    logic [CACHE_MASTERID_W-1:0] resp_b;
    logic                        route_ok;

    // Route check: in-range bank index, spare bid msb clear, and our own core id.
    always_comb begin
        resp_b   = scu_pc_resp_i.id.bid[CACHE_MASTERID_W-1:0];
        route_ok = ~scu_pc_resp_i.id.bid[CACHE_MASTERID_W]
                 & (int'(resp_b) < N_BANK)
                 & (scu_pc_resp_i.id.cid == CACHE_COREID_W'(CORE_ID));
    end

`ifdef RVH_L1D_WB_ARB_RESP_PIPE_EN
    logic               rsp_vld_q, rsp_vld_d;
    logic [PTR_W-1:0]   rsp_bank_q, rsp_bank_d;
    cache_scu_cc_resp_t rsp_pay_q, rsp_pay_d;
    logic               rsp_deq;

    // Registered response slot: drains to its bank, refills in the same cycle when drained.
    always_comb begin
        rsp_deq         = 1'b0;
        bank_resp_vld_o = '0;
        for (int j = 0; j < N_BANK; j++) begin
            bank_resp_o[j] = rsp_pay_q;
            if (rsp_vld_q && rsp_bank_q == PTR_W'(j)) begin
                bank_resp_vld_o[j] = 1'b1;
                rsp_deq            = bank_resp_rdy_i[j];
            end
        end
        scu_pc_resp_rdy_o = ~rsp_vld_q | rsp_deq;
        misroute_d        = scu_pc_resp_vld_i & scu_pc_resp_rdy_o & ~route_ok;
        rsp_vld_d         = rsp_vld_q & ~rsp_deq;
        rsp_bank_d        = rsp_bank_q;
        rsp_pay_d         = rsp_pay_q;
        if (scu_pc_resp_vld_i && scu_pc_resp_rdy_o && route_ok) begin
            rsp_vld_d  = 1'b1;
            rsp_bank_d = PTR_W'(resp_b);
            rsp_pay_d  = scu_pc_resp_i;
        end
    end

    // Response slot state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_vld_q  <= 1'b0;
            rsp_bank_q <= '0;
            rsp_pay_q  <= '0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_bank_q <= rsp_bank_d;
            rsp_pay_q  <= rsp_pay_d;
        end
    end
`else
    // Combinational routing: misrouted responses are swallowed so the SCU never stalls on them.
    always_comb begin
        bank_resp_vld_o   = '0;
        scu_pc_resp_rdy_o = ~route_ok;
        misroute_d        = scu_pc_resp_vld_i & ~route_ok;
        for (int j = 0; j < N_BANK; j++) begin
            bank_resp_o[j] = scu_pc_resp_i;
            if (route_ok && int'(resp_b) == j) begin
                bank_resp_vld_o[j] = scu_pc_resp_vld_i;
                scu_pc_resp_rdy_o  = bank_resp_rdy_i[j];
            end
        end
    end
`endif

    // Channel registers, pointers and the misroute pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ev_vld_q   <= 1'b0;
            dt_vld_q   <= 1'b0;
            ev_ptr_q   <= '0;
            dt_ptr_q   <= '0;
            ev_pay_q   <= '0;
            dt_pay_q   <= '0;
            misroute_q <= 1'b0;
        end else begin
            ev_vld_q   <= ev_vld_d;
            dt_vld_q   <= dt_vld_d;
            ev_ptr_q   <= ev_ptr_d;
            dt_ptr_q   <= dt_ptr_d;
            ev_pay_q   <= ev_pay_d;
            dt_pay_q   <= dt_pay_d;
            misroute_q <= misroute_d;
        end
    end

    assign pc_scu_evict_vld_o = ev_vld_q;
    assign pc_scu_evict_o     = ev_pay_q;
    assign pc_scu_data_vld_o  = dt_vld_q;
    assign pc_scu_data_o      = dt_pay_q;
    assign resp_misroute_o    = misroute_q;

`ifndef SYNTHESIS
    a_ev_rdy_onehot: assert property (@(posedge clk) $onehot0(bank_evict_rdy_o));
    a_dt_rdy_onehot: assert property (@(posedge clk) $onehot0(bank_data_rdy_o));
    a_ev_stable: assert property (@(posedge clk) disable iff (!rst)
        pc_scu_evict_vld_o && !pc_scu_evict_rdy_i |=> pc_scu_evict_vld_o && $stable(pc_scu_evict_o));
    a_dt_stable: assert property (@(posedge clk) disable iff (!rst)
        pc_scu_data_vld_o && !pc_scu_data_rdy_i |=> pc_scu_data_vld_o && $stable(pc_scu_data_o));
    a_resp_known: assert property (@(posedge clk) disable iff (!rst)
        scu_pc_resp_vld_i && scu_pc_resp_rdy_o |-> !$isunknown(scu_pc_resp_i));
`endif

endmodule

// File: tb/tb_rvh_l1d_wb_arb.sv
// tb/tb_rvh_l1d_wb_arb.sv - randomized scoreboard bench for rvh_l1d_wb_arb
module tb_rvh_l1d_wb_arb;
    import rvh_l1d_wb_arb_pkg::*;

    localparam int NB  = 4;
    localparam int CID = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic               [NB-1:0] ev_vld, ev_rdy, dt_vld, dt_rdy, rsp_vld, rsp_rdy;
    cache_scu_cc_req_t  [NB-1:0] ev_in;
    cache_scu_cc_data_t [NB-1:0] dt_in;
    cache_scu_cc_resp_t [NB-1:0] rsp_out;
    logic pc_ev_vld, pc_ev_rdy, pc_dt_vld, pc_dt_rdy, scu_vld, scu_rdy, misroute;
    cache_scu_cc_req_t  pc_ev;
    cache_scu_cc_data_t pc_dt;
    cache_scu_cc_resp_t scu_rsp;

    int checks = 0;
    int errors = 0;

    // Scoreboard state: one-deep output queues and rotating priority per channel.
    cache_scu_cc_req_t  ev_q[$];
    cache_scu_cc_data_t dt_q[$];
    int  ev_ptr, dt_ptr;
    bit  exp_mis;

    rvh_l1d_wb_arb #(.N_BANK(NB), .CORE_ID(CID)) dut (
        .clk(clk), .rst(rst),
        .bank_evict_vld_i(ev_vld), .bank_evict_i(ev_in), .bank_evict_rdy_o(ev_rdy),
        .bank_data_vld_i(dt_vld), .bank_data_i(dt_in), .bank_data_rdy_o(dt_rdy),
        .bank_resp_vld_o(rsp_vld), .bank_resp_o(rsp_out), .bank_resp_rdy_i(rsp_rdy),
        .pc_scu_evict_vld_o(pc_ev_vld), .pc_scu_evict_o(pc_ev), .pc_scu_evict_rdy_i(pc_ev_rdy),
        .pc_scu_data_vld_o(pc_dt_vld), .pc_scu_data_o(pc_dt), .pc_scu_data_rdy_i(pc_dt_rdy),
        .scu_pc_resp_vld_i(scu_vld), .scu_pc_resp_i(scu_rsp), .scu_pc_resp_rdy_o(scu_rdy),
        .resp_misroute_o(misroute)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Rotating priority: scan banks starting at ptr.
    function automatic int pick(input logic [NB-1:0] v, input int ptr);
        for (int k = 0; k < NB; k++)
            if (v[(ptr + k) % NB]) return (ptr + k) % NB;
        return -1;
    endfunction

    task automatic randomize_payloads();
        logic [127:0] r;
        for (int b = 0; b < NB; b++) begin
            r = rnd128(); ev_in[b] = r[$bits(cache_scu_cc_req_t)-1:0];
            r = rnd128(); dt_in[b] = r[$bits(cache_scu_cc_data_t)-1:0];
        end
        r = rnd128(); scu_rsp = r[$bits(cache_scu_cc_resp_t)-1:0];
    endtask

    task automatic set_resp(input bit v, input int bid, input int cid);
        scu_vld        = v;
        scu_rsp.id.bid = 4'(bid);
        scu_rsp.id.cid = 4'(cid);
    endtask

    task automatic idle();
        ev_vld = '0; dt_vld = '0; scu_vld = 1'b0;
        pc_ev_rdy = 1'b1; pc_dt_rdy = 1'b1; rsp_rdy = '1;
    endtask

    // One clock with the currently driven inputs, checked against the scoreboard.
    task automatic step();
        int w, bidv;
        bit ok;
        logic [NB-1:0] exp_v;
        bit exp_r;
        #1;
        // evict channel
        w = pick(ev_vld, ev_ptr);
        if (ev_q.size() != 0 && pc_ev_rdy) void'(ev_q.pop_front());
        if (w >= 0 && ev_q.size() == 0) begin
            check_eq("ev_rdy", 128'(ev_rdy), 128'(1 << w));
            ev_q.push_back(ev_in[w]);
            ev_ptr = (w + 1) % NB;
        end else begin
            check_eq("ev_rdy", 128'(ev_rdy), 128'(0));
        end
        // data channel
        w = pick(dt_vld, dt_ptr);
        if (dt_q.size() != 0 && pc_dt_rdy) void'(dt_q.pop_front());
        if (w >= 0 && dt_q.size() == 0) begin
            check_eq("dt_rdy", 128'(dt_rdy), 128'(1 << w));
            dt_q.push_back(dt_in[w]);
            dt_ptr = (w + 1) % NB;
        end else begin
            check_eq("dt_rdy", 128'(dt_rdy), 128'(0));
        end
        // response routing
        bidv  = int'(scu_rsp.id.bid);
        ok    = (bidv < NB) && (int'(scu_rsp.id.cid) == CID);
        exp_v = (scu_vld && ok) ? NB'(1 << bidv) : '0;
        exp_r = ok ? rsp_rdy[bidv % NB] : 1'b1;
        check_eq("resp_vld", 128'(rsp_vld), 128'(exp_v));
        check_eq("resp_rdy", 128'(scu_rdy), 128'(exp_r));
        check_eq("resp_pay", 128'(rsp_out[NB-1]), 128'(scu_rsp));
        exp_mis = scu_vld && !ok;
        @(posedge clk); #1;
        check_eq("ev_vld_o", 128'(pc_ev_vld), 128'(ev_q.size() != 0));
        if (ev_q.size() != 0) check_eq("ev_pay_o", 128'(pc_ev), 128'(ev_q[0]));
        check_eq("dt_vld_o", 128'(pc_dt_vld), 128'(dt_q.size() != 0));
        if (dt_q.size() != 0) check_eq("dt_pay_o", 128'(pc_dt), 128'(dt_q[0]));
        check_eq("misroute", 128'(misroute), 128'(exp_mis));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_ev_vld", 128'(pc_ev_vld), 128'(0));
        check_eq("rst_dt_vld", 128'(pc_dt_vld), 128'(0));
        check_eq("rst_mis", 128'(misroute), 128'(0));
        rst = 1'b1;
        ev_q.delete(); dt_q.delete();
        ev_ptr = 0; dt_ptr = 0;
    endtask

    initial begin
        idle();
        randomize_payloads();
        set_resp(1'b0, 0, CID);
        @(posedge clk); #1;
        do_reset();

        // both low banks request four cycles: alternating grants 0,1,0,1
        ev_vld = 4'b0011;
        for (int i = 0; i < 4; i++) begin randomize_payloads(); set_resp(1'b0, 0, CID); step(); end
        idle(); step();

        // bank 1 data held under a 3-cycle stall, then drained
        dt_vld = 4'b0010; pc_dt_rdy = 1'b0; randomize_payloads(); set_resp(1'b0, 0, CID);
        for (int i = 0; i < 3; i++) begin step(); randomize_payloads(); set_resp(1'b0, 0, CID); end
        dt_vld = '0; pc_dt_rdy = 1'b1; step(); step();

        // pointer wrap: grant bank 2 (ptr->3), then banks 0 and 3 -> 3, then 0
        ev_vld = 4'b0100; step();
        ev_vld = 4'b1001; step();
        ev_vld = 4'b0001; step();
        idle(); step();

        // response routing, good and bad
        set_resp(1'b1, 1, CID); rsp_rdy = 4'b0010; step();
        rsp_rdy = 4'b1101; step();
        set_resp(1'b1, 5, CID); rsp_rdy = 4'b0000; step();
        set_resp(1'b1, 2, CID + 1); step();
        idle(); step();

        // reset with both output registers full and stalled
        ev_vld = 4'b1000; dt_vld = 4'b0100; pc_ev_rdy = 1'b0; pc_dt_rdy = 1'b0;
        step(); step();
        idle(); do_reset(); step(); step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            randomize_payloads();
            ev_vld    = NB'($urandom()) & NB'($urandom());
            dt_vld    = NB'($urandom());
            pc_ev_rdy = ($urandom_range(0, 9) < 7);
            pc_dt_rdy = ($urandom_range(0, 9) < 5);
            rsp_rdy   = NB'($urandom());
            set_resp($urandom_range(0, 1) == 1,
                     ($urandom_range(0, 7) < 6) ? $urandom_range(0, NB - 1) : $urandom_range(0, 15),
                     ($urandom_range(0, 4) != 0) ? CID : $urandom_range(0, 15));
            step();
            if (i == 300) begin idle(); do_reset(); end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvh_l1d_wb_arb.md
Name: rvh_l1d_wb_arb

Overview:
- Core-level writeback/evict merger sitting directly downstream of the per-bank L1D eviction/writeback queues.
- Arbitrates N_BANK evict-request streams and N_BANK writeback-data streams onto the single private-cache -> SCU tx port pair (evict, data).
- Routes SCU -> private-cache responses back to the owning bank by id.bid.
- Per-channel round-robin arbitration with a one-entry registered output stage; response path combinational by default.

Parameters:
- N_BANK, 2, number of L1D banks feeding the merger (1..8).
- CORE_ID, 0, core index; checked against resp id.cid.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- bank_evict_vld_i  in  N_BANK  per-bank evict/wb request valid.
- bank_evict_i  in  N_BANK x cache_scu_cc_req_t  per-bank evict/wb request.
- bank_evict_rdy_o  out  N_BANK  per-bank request accepted.
- bank_data_vld_i  in  N_BANK  per-bank writeback data valid.
- bank_data_i  in  N_BANK x cache_scu_cc_data_t  per-bank writeback data.
- bank_data_rdy_o  out  N_BANK  per-bank data accepted.
- bank_resp_vld_o  out  N_BANK  response valid to bank.
- bank_resp_o  out  N_BANK x cache_scu_cc_resp_t  response payload, broadcast to all banks.
- bank_resp_rdy_i  in  N_BANK  bank response ready.
- pc_scu_evict_vld_o  out  1  merged evict valid.
- pc_scu_evict_o  out  cache_scu_cc_req_t  merged evict payload.
- pc_scu_evict_rdy_i  in  1  SCU evict ready.
- pc_scu_data_vld_o  out  1  merged data valid.
- pc_scu_data_o  out  cache_scu_cc_data_t  merged data payload.
- pc_scu_data_rdy_i  in  1  SCU data ready.
- scu_pc_resp_vld_i  in  1  SCU response valid.
- scu_pc_resp_i  in  cache_scu_cc_resp_t  SCU response payload.
- scu_pc_resp_rdy_o  out  1  response ready.
- resp_misroute_o  out  1  pulse: response dropped, bad bid or cid.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-low; all state updates on posedge clk.
- Reset values: all *_vld_o = 0; resp_misroute_o = 0; RR pointers = 0; output regs empty; payload regs = 0.
- Channels: evict and data channels are independent and identical in structure. Each has:
  - an N_BANK round-robin arbiter with pointer ptr;
  - a one-entry output register: out_vld plus payload.
- Register load and ready:
  - Register loads when (~out_vld | out_rdy_i) and any request is valid.
  - The winner bank gets rdy_o = 1 in that same cycle; all other banks get rdy_o = 0.
  - No bank sees rdy while the register is full and downstream is stalled.
- Throughput and latency:
  - 1 transfer/cycle sustained.
  - Latency 1 cycle: bank handshake at cycle t -> pc_scu_*_vld_o at t+1.
- Arbitration order:
  - Grant goes to the first valid bank at or after ptr, wrapping modulo N_BANK.
  - On grant to bank g: ptr <= (g+1) mod N_BANK, so the pointer wraps from N_BANK-1 to 0.
  - With no grant, ptr holds.
- Stalls:
  - Output payload and valid are stable while vld=1 and rdy_i=0.
  - Unselected inputs are not sampled.
- Payload handling: the payload passes unmodified; no field rewrite (bid is already set by the bank).
- Response routing:
  - b = scu_pc_resp_i.id.bid[CACHE_MASTERID_W-1:0].
  - Valid route: b < N_BANK, bid msb == 0, and id.cid == CORE_ID.
    - bank_resp_vld_o[b] = scu_pc_resp_vld_i.
    - scu_pc_resp_rdy_o = bank_resp_rdy_i[b].
    - Every other bank's resp vld = 0.
  - Misroute (any route condition fails):
    - response is dropped: rdy_o = 1, no bank vld;
    - resp_misroute_o = 1 for that cycle (registered pulse, asserted the following cycle).
- Simultaneous events:
  - Evict grant and data grant to different banks in the same cycle are allowed.
  - Response delivery is independent of both tx channels.
- Reset mid-operation: pending output-register contents are discarded with no SCU handshake; banks must re-issue.
- Assertions (non-SYNTHESIS):
  - at most one bank_*_rdy_o set per channel;
  - output payload stable under stall;
  - no X on scu_pc_resp_i when vld and rdy are both high.

Optional Feature:
- RVH_L1D_WB_ARB_RESP_PIPE_EN defined:
  - The response path gets a one-entry register; response latency is 1 cycle.
  - scu_pc_resp_rdy_o = ~resp_reg_vld | bank_resp_rdy_i[resp_reg_bank].
  - Misrouted responses are dropped at capture: the register is not filled, and resp_misroute_o still pulses.
- Undefined: the response path is combinational, as described in Behaviour.

Test Plan:
- N_BANK=2, both banks assert evict valid for 4 cycles, SCU rdy=1 -> grants alternate 0,1,0,1; pc_scu_evict_vld_o rises one cycle after the first grant; 4 transfers in 4 cycles.
- Bank 1 data valid, pc_scu_data_rdy_i=0 for 3 cycles -> register holds bank-1 payload unchanged; bank_data_rdy_o=2'b00 after the first load; release -> drains in 1 cycle.
- N_BANK=4, ptr=3, banks 0 and 3 valid -> bank 3 granted, ptr wraps to 0; next cycle bank 0 granted, ptr=1.
- Response: bid=1, cid=CORE_ID, bank_resp_rdy_i=4'b0010 -> bank_resp_vld_o=4'b0010 and scu_pc_resp_rdy_o=1; with bank_resp_rdy_i[1]=0 -> scu_pc_resp_rdy_o=0.
- Response with bid=5 (N_BANK=4) or wrong cid -> no bank vld; scu_pc_resp_rdy_o=1; resp_misroute_o pulses one cycle.
- rst=0 asserted while both output registers are full -> next cycle all vld_o=0 and ptrs=0; pre-reset payload is never presented to the SCU.
